// File: rtl/icache_ctrl.sv
// icache_ctrl: read-only 2-way set-associative instruction cache controller with 4-word line refill.
// Define ICACHE_STATS_EN to add saturating hit/miss counters (stat_hits_o, stat_misses_o).
module icache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int SET_BITS = 6,
  localparam int TAG_W = ADDR_WIDTH - SET_BITS - 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  output logic                  cpu_gnt_o,
  output logic                  cpu_rvalid_o,
  output logic [31:0]           cpu_rdata_o,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic [SET_BITS-1:0]   cm_set_o,
  output logic                  cm_way_o,
  output logic                  cm_enable_o,
  output logic                  cm_write_enable_o,
  output logic                  cm_val_write_enable_o,
  output logic                  cm_line_valid_o,
  output logic [TAG_W-1:0]      cm_line_tag_o,
  output logic [127:0]          cm_line_o,
  output logic [15:0]           cm_line_be_o,
  input  logic [1:0]            cm_line_valid_i,
  input  logic [2*TAG_W-1:0]    cm_line_tag_i,
  input  logic [127:0]          cm_line_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits_o,
  output logic [31:0]           stat_misses_o
`endif
);
  typedef enum logic [2:0] {IDLE, TAG_CMP, DATA, REFILL, LINE_WR, FLUSH} state_t;
  state_t state, state_d;
  logic [ADDR_WIDTH-1:2] addr_q;
  logic [TAG_W-1:0] tag_q;
  logic [SET_BITS-1:0] set_q;
  logic [1:0] hit_w;
  logic hit, rr_way, victim_q, flush_pend;
  logic [2:0] gnt_cnt;
  logic [1:0] rsp_cnt;
  logic [SET_BITS:0] flush_cnt;
  logic [127:0] buf_q, line_sel;
  logic [31:0] word_sel;
  logic unused_ok;
  assign unused_ok = ^cpu_addr_i[1:0];
  assign tag_q = addr_q[ADDR_WIDTH-1:SET_BITS+4];
  assign set_q = addr_q[SET_BITS+3:4];
  assign hit_w[0] = cm_line_valid_i[0] && cm_line_tag_i[TAG_W-1:0] == tag_q;
  assign hit_w[1] = cm_line_valid_i[1] && cm_line_tag_i[2*TAG_W-1:TAG_W] == tag_q;
  assign hit = |hit_w;
  assign line_sel = state == LINE_WR ? buf_q : cm_line_i;
  assign word_sel = line_sel[{addr_q[3:2], 5'd0} +: 32];
  assign busy_o = state != IDLE;
  assign cm_line_be_o = 16'hFFFF;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_way <= 1'b0;
      flush_pend <= 1'b0;
      gnt_cnt <= '0;
      rsp_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_d;
      flush_pend <= state != FLUSH && (flush_pend || (flush_i && state != IDLE));
      flush_cnt <= state == FLUSH ? flush_cnt + 1'b1 : '0;
      if (cpu_gnt_o) addr_q <= cpu_addr_i[ADDR_WIDTH-1:2];
      if (state == TAG_CMP) begin
        victim_q <= cm_line_valid_i[0] ? (cm_line_valid_i[1] ? rr_way : 1'b1) : 1'b0;
        gnt_cnt <= '0;
        rsp_cnt <= '0;
      end
      if (state == REFILL && mem_req_o && mem_gnt_i) gnt_cnt <= gnt_cnt + 3'd1;
      if (state == REFILL && mem_rvalid_i) begin
        buf_q[{rsp_cnt, 5'd0} +: 32] <= mem_rdata_i;
        rsp_cnt <= rsp_cnt + 2'd1;
      end
      if (state == LINE_WR) rr_way <= ~rr_way;
    end
  end
  always_comb begin
    state_d = state;
    cpu_gnt_o = 1'b0;
    cpu_rvalid_o = 1'b0;
    cpu_rdata_o = '0;
    mem_req_o = 1'b0;
    mem_addr_o = '0;
    cm_set_o = '0;
    cm_way_o = 1'b0;
    cm_enable_o = 1'b0;
    cm_write_enable_o = 1'b0;
    cm_val_write_enable_o = 1'b0;
    cm_line_valid_o = 1'b0;
    cm_line_tag_o = '0;
    cm_line_o = '0;
    case (state)
      IDLE: begin
        cpu_gnt_o = cpu_req_i && !flush_pend && !flush_i;
        cm_set_o = cpu_gnt_o ? cpu_addr_i[SET_BITS+3:4] : '0;
        cm_enable_o = cpu_gnt_o;
        state_d = (flush_pend || flush_i) ? FLUSH : cpu_req_i ? TAG_CMP : IDLE;
      end
      TAG_CMP: begin
        // way 0 wins if both ways claim the tag
        cm_set_o = hit ? set_q : '0;
        cm_way_o = hit && !hit_w[0];
        cm_enable_o = hit;
        state_d = hit ? DATA : REFILL;
      end
      DATA: begin
        cpu_rvalid_o = 1'b1;
        cpu_rdata_o = word_sel;
        state_d = IDLE;
      end
      REFILL: begin
        mem_req_o = !gnt_cnt[2];
        mem_addr_o = mem_req_o ? {addr_q[ADDR_WIDTH-1:4], gnt_cnt[1:0], 2'b00} : '0;
        state_d = (mem_rvalid_i && &rsp_cnt) ? LINE_WR : REFILL;
      end
      LINE_WR: begin
        cm_set_o = set_q;
        cm_way_o = victim_q;
        cm_enable_o = 1'b1;
        cm_write_enable_o = 1'b1;
        cm_val_write_enable_o = 1'b1;
        cm_line_valid_o = 1'b1;
        cm_line_tag_o = tag_q;
        cm_line_o = buf_q;
        cpu_rvalid_o = 1'b1;
        cpu_rdata_o = word_sel;
        state_d = IDLE;
      end
      FLUSH: begin
        cm_set_o = flush_cnt[SET_BITS:1];
        cm_way_o = flush_cnt[0];
        cm_enable_o = 1'b1;
        cm_val_write_enable_o = 1'b1;
        state_d = &flush_cnt ? IDLE : FLUSH;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits_o <= '0;
      stat_misses_o <= '0;
    end else if (state == TAG_CMP) begin
      stat_hits_o <= stat_hits_o + 32'(hit && !(&stat_hits_o));
      stat_misses_o <= stat_misses_o + 32'(!hit && !(&stat_misses_o));
    end
  end
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: randomized bench for icache_ctrl with line-array and memory-bus models
// and a set-level cache reference model (hit/miss, victim, returned word, flush).
module tb_icache_ctrl;
  logic clk, reset, cpu_req_i, cpu_gnt_o, cpu_rvalid_o, flush_i, busy_o;
  logic [31:0] cpu_addr_i, cpu_rdata_o, mem_addr_o, mem_rdata_i;
  logic mem_req_o, mem_gnt_i, mem_rvalid_i;
  logic [5:0] cm_set_o;
  logic cm_way_o, cm_enable_o, cm_write_enable_o, cm_val_write_enable_o, cm_line_valid_o;
  logic [21:0] cm_line_tag_o;
  logic [127:0] cm_line_o, cm_line_i;
  logic [15:0] cm_line_be_o;
  logic [1:0] cm_line_valid_i;
  logic [43:0] cm_line_tag_i;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits_o, stat_misses_o;
`endif
  icache_ctrl dut (
    .clk(clk), .reset(reset), .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
    .flush_i(flush_i), .busy_o(busy_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .cm_set_o(cm_set_o), .cm_way_o(cm_way_o), .cm_enable_o(cm_enable_o),
    .cm_write_enable_o(cm_write_enable_o), .cm_val_write_enable_o(cm_val_write_enable_o),
    .cm_line_valid_o(cm_line_valid_o), .cm_line_tag_o(cm_line_tag_o), .cm_line_o(cm_line_o),
    .cm_line_be_o(cm_line_be_o), .cm_line_valid_i(cm_line_valid_i),
    .cm_line_tag_i(cm_line_tag_i), .cm_line_i(cm_line_i)
`ifdef ICACHE_STATS_EN
    , .stat_hits_o(stat_hits_o), .stat_misses_o(stat_misses_o)
`endif
  );
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[17:2], ~a[31:16]} ^ 32'h3C5A_96E1;
  endfunction
  initial clk = 0;
  always #5 clk = ~clk;
  // line array: synchronous read, writes take effect at the enabled edge
  bit av[64][2];
  logic [21:0] at[64][2];
  logic [127:0] ad[64][2];
  logic [28:0] wr_log[$];
  int clr_cnt = 0;
  always @(posedge clk) begin
    if (cm_enable_o) begin
      if (cm_val_write_enable_o) begin
        av[cm_set_o][cm_way_o] <= cm_line_valid_o;
        if (!cm_line_valid_o) clr_cnt <= clr_cnt + 1;
      end
      if (cm_write_enable_o) begin
        at[cm_set_o][cm_way_o] <= cm_line_tag_o;
        ad[cm_set_o][cm_way_o] <= cm_line_o;
        wr_log.push_back({cm_set_o, cm_way_o, cm_line_tag_o});
      end
      cm_line_valid_i <= {av[cm_set_o][1], av[cm_set_o][0]};
      cm_line_tag_i <= {at[cm_set_o][1], at[cm_set_o][0]};
      cm_line_i <= ad[cm_set_o][cm_way_o];
    end
  end
  // memory bus: grant after gwait cycles, in-order responses after a random latency
  typedef struct {logic [31:0] a; int t;} rsp_t;
  rsp_t rq[$];
  logic [31:0] mem_log[$];
  logic [31:0] gaddr;
  int gmin = 0, gmax = 0, rmin = 1, rmax = 1, gwait = 0, ncyc = 0, rcnt = 0;
  always @(negedge clk) begin
    ncyc++;
    mem_rvalid_i = 0;
    mem_rdata_i = 0;
    if (reset) begin
      rq.delete();
      mem_gnt_i = 0;
      gwait = 0;
    end else begin
      if (mem_gnt_i) begin
        rq.push_back('{gaddr, ncyc + $urandom_range(rmax, rmin) - 1});
        mem_log.push_back(gaddr);
        gwait = $urandom_range(gmax, gmin);
      end
      if (rq.size() > 0 && rq[0].t <= ncyc) begin
        mem_rvalid_i = 1;
        mem_rdata_i = mem_word(rq[0].a);
        void'(rq.pop_front());
        rcnt++;
      end
      mem_gnt_i = 0;
      if (mem_req_o) begin
        if (gwait == 0) begin
          mem_gnt_i = 1;
          gaddr = mem_addr_o;
        end else gwait--;
      end
    end
  end
  // reference: per-set valid/tag, round-robin bit toggled on every miss
  bit mv[64][2];
  logic [21:0] mt[64][2];
  bit mrr = 0;
  int hits_n = 0, misses_n = 0;
  task automatic model_reset();
    mrr = 0;
    hits_n = 0;
    misses_n = 0;
  endtask
  task automatic check_reset_outs();
    check("rst_outs", 64'(|{cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o, busy_o, mem_req_o, mem_addr_o,
      cm_set_o, cm_way_o, cm_enable_o, cm_write_enable_o, cm_val_write_enable_o,
      cm_line_valid_o, cm_line_tag_o, cm_line_o}), 0);
    check("rst_be", 64'(cm_line_be_o), 64'hFFFF);
  endtask
  task automatic wait_flush();
    int n = 0, w = 0;
    clr_cnt = 0;
    while (!busy_o && w < 4) begin @(negedge clk); w++; end
    while (busy_o && n < 400) begin n++; @(negedge clk); end
    check("flush_len", 64'(n), 128);
    check("flush_clears", 64'(clr_cnt), 128);
    for (int s = 0; s < 64; s++) begin mv[s][0] = 0; mv[s][1] = 0; end
  endtask
  task automatic fetch(input logic [31:0] a, input bit do_flush);
    int s, k, to;
    logic [21:0] t;
    bit h, w;
    s = int'(a[9:4]);
    t = a[31:10];
    h = (mv[s][0] && mt[s][0] == t) || (mv[s][1] && mt[s][1] == t);
    mem_log.delete();
    wr_log.delete();
    cpu_req_i = 1;
    cpu_addr_i = a;
    #1;
    to = 0;
    while (!cpu_gnt_o && to < 400) begin @(negedge clk); #1; to++; end
    check("gnt", 64'(cpu_gnt_o), 1);
    @(posedge clk);
    @(negedge clk);
    cpu_req_i = 0;
    flush_i = do_flush;
    k = 1;
    while (!cpu_rvalid_o && k < 200) begin @(negedge clk); flush_i = 0; k++; end
    flush_i = 0;
    check("rvalid", 64'(cpu_rvalid_o), 1);
    check("rdata", 64'(cpu_rdata_o), 64'(mem_word({a[31:2], 2'b00})));
    if (h) check("hit_lat", 64'(k), 2);
    check("mem_reads", 64'(mem_log.size()), h ? 0 : 4);
    for (int i = 0; i < mem_log.size() && i < 4; i++)
      check("mem_addr", 64'(mem_log[i]), 64'({a[31:4], 4'(i * 4)}));
    @(negedge clk);
    if (h) begin
      hits_n++;
      check("hit_nowrite", 64'(wr_log.size()), 0);
    end else begin
      misses_n++;
      w = !mv[s][0] ? 1'b0 : !mv[s][1] ? 1'b1 : mrr;
      mrr = !mrr;
      mv[s][w] = 1;
      mt[s][w] = t;
      check("line_wr_cnt", 64'(wr_log.size()), 1);
      if (wr_log.size() > 0) check("line_wr", 64'(wr_log[0]), 64'({a[9:4], w, t}));
    end
    if (do_flush) wait_flush();
  endtask
  initial begin
    logic [5:0] sets[3];
    logic [21:0] tags[5];
    int to;
    sets = '{6'h23, 6'h05, 6'h3F};
    tags = '{22'h0, 22'h1, 22'h2, 22'h3, 22'h3FFFFF};
    reset = 1;
    cpu_req_i = 0;
    cpu_addr_i = 0;
    flush_i = 0;
    repeat (3) @(negedge clk);
    check_reset_outs();
    reset = 0;
    model_reset();
    @(negedge clk);
    fetch(32'h0000_1234, 0);
    fetch(32'h0000_1238, 0);
    fetch(32'h0001_0234, 0);
    fetch(32'h0002_0234, 0);
    fetch(32'h0000_1234, 0);
    gmin = 3; gmax = 3; rmin = 2; rmax = 2;
    fetch(32'h0003_0100, 0);
    gmin = 0; gmax = 1; rmin = 1; rmax = 2;
    fetch(32'h0004_0208, 1);
    fetch(32'h0004_0208, 0);
    // reset with two refill words already delivered
    gmin = 2; gmax = 2; rmin = 1; rmax = 1;
    mem_log.delete();
    wr_log.delete();
    cpu_req_i = 1;
    cpu_addr_i = 32'h0005_5670;
    #1;
    to = 0;
    while (!cpu_gnt_o && to < 400) begin @(negedge clk); #1; to++; end
    @(posedge clk);
    @(negedge clk);
    cpu_req_i = 0;
    rcnt = 0;
    to = 0;
    while (rcnt < 2 && to < 200) begin @(negedge clk); to++; end
    check("two_words", 64'(rcnt), 2);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check_reset_outs();
    repeat (2) @(negedge clk);
    reset = 0;
    model_reset();
    check("abort_nowrite", 64'(wr_log.size()), 0);
    @(negedge clk);
    fetch(32'h0005_5670, 0);
    for (int i = 0; i < 120; i++) begin
      gmin = $urandom_range(1, 0);
      gmax = gmin + $urandom_range(3, 0);
      rmin = $urandom_range(2, 1);
      rmax = rmin + $urandom_range(2, 0);
      if ($urandom_range(19, 0) == 0) begin
        flush_i = 1;
        @(negedge clk);
        flush_i = 0;
        wait_flush();
      end
      fetch({tags[$urandom_range(4, 0)], sets[$urandom_range(2, 0)], 4'($urandom)},
            $urandom_range(14, 0) == 0);
    end
`ifdef ICACHE_STATS_EN
    check("stat_hits", 64'(stat_hits_o), 64'(hits_n));
    check("stat_misses", 64'(stat_misses_o), 64'(misses_n));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
